// File: rtl/vector_stream_tx.sv
// Serializes wide parallel vectors into a BUS_WIDTH AXI-Stream, LSB-first and
// packed back-to-back, then flushes the zero-padded tail beat on i_Last.
module vector_stream_tx #(
  parameter int BUS_WIDTH    = 128,
  parameter int VECTOR_WIDTH = 920,
  parameter int LVL_WIDTH    = $clog2(VECTOR_WIDTH + BUS_WIDTH)
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [VECTOR_WIDTH-1:0] i_Vector,
  input  logic                    i_Valid,
  input  logic                    i_Last,
  output logic                    o_Ready,
  output logic [BUS_WIDTH-1:0]    M_AXIS_DATA_tdata,
  output logic                    M_AXIS_DATA_tvalid,
  output logic                    M_AXIS_DATA_tlast,
  input  logic                    M_AXIS_DATA_tready,
  output logic [15:0]             o_VecCnt
);

  localparam int BUF_WIDTH = VECTOR_WIDTH + BUS_WIDTH;
  localparam logic [LVL_WIDTH-1:0] BUS_LVL = LVL_WIDTH'(BUS_WIDTH);
  localparam logic [LVL_WIDTH-1:0] VEC_LVL = LVL_WIDTH'(VECTOR_WIDTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state_reg, state_next;
  logic [BUF_WIDTH-1:0]   buf_reg, buf_next;
  logic [LVL_WIDTH-1:0]   lvl_reg, lvl_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic                   accept;
  logic                   xfer;

  // All stream outputs decode registered state only, so they stay stable
  // under backpressure and never depend combinationally on tready.
  assign o_Ready            = (state_reg == RUN) && (lvl_reg < BUS_LVL);
  assign M_AXIS_DATA_tvalid = (lvl_reg >= BUS_LVL) ||
                              ((state_reg == FLUSH) && (lvl_reg != '0));
  assign M_AXIS_DATA_tlast  = (state_reg == FLUSH) && (lvl_reg <= BUS_LVL) &&
                              (lvl_reg != '0);
  assign M_AXIS_DATA_tdata  = buf_reg[BUS_WIDTH-1:0];
  assign o_VecCnt           = cnt_reg;

  assign accept = i_Valid && o_Ready;
  assign xfer   = M_AXIS_DATA_tvalid && M_AXIS_DATA_tready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // accept and xfer are mutually exclusive: o_Ready implies lvl < BUS_WIDTH
  // in RUN (no beat pending), and o_Ready is low throughout FLUSH.
  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    lvl_next   = lvl_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      buf_next = buf_reg | ({{BUS_WIDTH{1'b0}}, i_Vector} << lvl_reg);
      lvl_next = lvl_reg + VEC_LVL;
      if (cnt_reg != 16'hFFFF) begin
        cnt_next = cnt_reg + 16'd1;
      end
      if (i_Last) begin
        state_next = FLUSH;
      end
    end else if (xfer) begin
      buf_next = buf_reg >> BUS_WIDTH;
      lvl_next = (lvl_reg > BUS_LVL) ? (lvl_reg - BUS_LVL) : '0;
      if (M_AXIS_DATA_tlast) begin
        state_next = RUN;
        lvl_next   = '0;
        cnt_next   = 16'd0;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      buf_reg <= '0;
      lvl_reg <= '0;
      cnt_reg <= 16'd0;
    end else begin
      buf_reg <= buf_next;
      lvl_reg <= lvl_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: tb/tb_vector_stream_tx.sv
// Directed bench for vector_stream_tx: expected beats are slices of a reference
// bitstream built by concatenating the stimulus vectors LSB-first.
module tb_vector_stream_tx;

  localparam int BW = 128;
  localparam int VW = 920;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic [VW-1:0] i_Vector = '0;
  logic          i_Valid = 1'b0;
  logic          i_Last = 1'b0;
  logic          o_Ready;
  logic [BW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b0;
  logic [15:0]   o_VecCnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [VW-1:0]     vecs [4];
  logic [4*VW-1:0]   stream_bits;
  logic [BW-1:0]     beat7_seen;

  vector_stream_tx #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW)) dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .i_Vector           (i_Vector),
    .i_Valid            (i_Valid),
    .i_Last             (i_Last),
    .o_Ready            (o_Ready),
    .M_AXIS_DATA_tdata  (tdata),
    .M_AXIS_DATA_tvalid (tvalid),
    .M_AXIS_DATA_tlast  (tlast),
    .M_AXIS_DATA_tready (tready),
    .o_VecCnt           (o_VecCnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Vector k gets bytes (i*3 + seed); builds the reference stream of n vectors.
  task automatic build(input int n, input int s0, input int s1, input int s2);
    int seeds [3];
    seeds[0] = s0; seeds[1] = s1; seeds[2] = s2;
    stream_bits = '0;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < VW / 8; i++) vecs[k][i*8 +: 8] = 8'(i * 3 + seeds[k]);
      stream_bits[k*VW +: VW] = vecs[k];
    end
  endtask

  function automatic logic [BW-1:0] exp_beat(input int b);
    return stream_bits[b*BW +: BW];
  endfunction

  task automatic drive(input int n);
    int cyc;
    @(negedge ap_clk);
    for (int k = 0; k < n; k++) begin
      i_Vector = vecs[k];
      i_Valid  = 1'b1;
      i_Last   = (k == n - 1);
      cyc = 0;
      while (!o_Ready && cyc < 3000) begin
        @(negedge ap_clk);
        cyc++;
      end
      if (!o_Ready) begin
        check("accept_timeout", 128'(cyc), 128'd0);
        i_Valid = 1'b0;
        return;
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
      check($sformatf("latency_v%0d", k), 128'(tvalid), 128'd1);
      $display("[TB] vector %0d accepted, o_VecCnt=%0d", k, o_VecCnt);
    end
    i_Valid = 1'b0;
    i_Last  = 1'b0;
  endtask

  task automatic monitor(input int n, input bit rnd);
    int b = 0;
    int cyc = 0;
    bit done = 0;
    bit stalled = 0;
    logic [BW-1:0] pd = '0;
    logic pl = 1'b0;
    int nbeats = (n * VW + BW - 1) / BW;
    while (!done && cyc < 3000) begin
      @(negedge ap_clk);
      cyc++;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tvalid) begin
        if (stalled) begin
          check("hold_data", tdata, pd);
          check("hold_last", 128'(tlast), 128'(pl));
        end
        if (tready) begin
          if (b < nbeats) begin
            check($sformatf("beat%0d_data", b), tdata, exp_beat(b));
            check($sformatf("beat%0d_last", b), 128'(tlast), 128'(b == nbeats - 1));
          end else begin
            check("extra_beat", 128'(b), 128'(nbeats - 1));
          end
          if (b == 7) beat7_seen = tdata;
          if (tlast) begin
            check("cnt_before_last", 128'(o_VecCnt), 128'(n));
            done = 1;
          end
          b++;
        end
        stalled = !tready;
        pd = tdata;
        pl = tlast;
      end else begin
        stalled = 0;
      end
    end
    if (!done) check("stream_timeout", 128'(cyc), 128'd0);
    check("beat_count", 128'(b), 128'(nbeats));
    tready = 1'b1;
    @(negedge ap_clk);
    check("cnt_after_last", 128'(o_VecCnt), 128'd0);
    check("idle_tvalid", 128'(tvalid), 128'd0);
    check("idle_ready", 128'(o_Ready), 128'd1);
    $display("[TB] stream of %0d vectors done, %0d beats", n, b);
  endtask

  task automatic run_stream(input int n, input bit rnd);
    fork
      drive(n);
      monitor(n, rnd);
    join
  endtask

  initial begin
    int quiet;
    // Reset state
    #12;
    check("rst_ready", 128'(o_Ready), 128'd1);
    check("rst_tvalid", 128'(tvalid), 128'd0);
    check("rst_tlast", 128'(tlast), 128'd0);
    check("rst_cnt", 128'(o_VecCnt), 128'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Single vector: 8 beats, tail beat carries vector bits 919:896
    build(1, 1, 0, 0);
    run_stream(1, 0);
    check("t1_tail_low", 128'(beat7_seen[23:0]), 128'(vecs[0][919:896]));
    check("t1_tail_zero", 128'(beat7_seen[127:24]), 128'd0);

    // Three vectors, full throughput downstream: 22 beats
    build(3, 17, 71, 133);
    run_stream(3, 0);
    check("t2_v2_start", 128'(beat7_seen[127:24]), 128'(vecs[1][103:0]));

    // Same shape with random backpressure
    build(3, 5, 9, 200);
    run_stream(3, 1);

    // Continuous i_Valid: vector 1 begins at beat 7 bit 24
    build(3, 40, 80, 120);
    run_stream(3, 0);
    check("t4_v1_tail", 128'(beat7_seen[23:0]), 128'(vecs[0][919:896]));
    check("t4_v2_start", 128'(beat7_seen[127:24]), 128'(vecs[1][103:0]));

    // Reset while beat 4 of a single-vector stream is presented
    build(1, 1, 0, 0);
    @(negedge ap_clk);
    tready   = 1'b1;
    i_Vector = vecs[0];
    i_Valid  = 1'b1;
    i_Last   = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    i_Valid = 1'b0;
    i_Last  = 1'b0;
    repeat (4) @(negedge ap_clk);
    check("pre_rst_beat4", tdata, exp_beat(4));
    ap_rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 128'(tvalid), 128'd0);
    check("mid_rst_tlast", 128'(tlast), 128'd0);
    check("mid_rst_ready", 128'(o_Ready), 128'd1);
    check("mid_rst_cnt", 128'(o_VecCnt), 128'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    quiet = 0;
    repeat (12) begin
      @(negedge ap_clk);
      if (tvalid || tlast) quiet++;
    end
    check("post_rst_quiet", 128'(quiet), 128'd0);
    run_stream(1, 0);
    check("t5_tail_low", 128'(beat7_seen[23:0]), 128'(vecs[0][919:896]));
    check("t5_tail_zero", 128'(beat7_seen[127:24]), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_stream_tx.md
VECTOR_STREAM_TX -- requirements
Module: vector_stream_tx

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 128, meaning the AXI-Stream data beat width in bits.
REQ-002 SHALL have parameter VECTOR_WIDTH, default 920, meaning the fingerprint vector width in bits.
REQ-003 SHALL have parameter LVL_WIDTH, default $clog2(VECTOR_WIDTH+BUS_WIDTH), meaning the width of the buffer fill-level counter.
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_Vector, input, VECTOR_WIDTH bits: the parallel vector to serialize.
REQ-007 SHALL have port i_Valid, input, 1 bit: i_Vector is valid.
REQ-008 SHALL have port i_Last, input, 1 bit: this vector ends the stream; qualified by i_Valid.
REQ-009 SHALL have port o_Ready, output, 1 bit: a vector is accepted on a cycle where i_Valid && o_Ready.
REQ-010 SHALL have port M_AXIS_DATA_tdata, output, BUS_WIDTH bits: the packed beat, LSB-first.
REQ-011 SHALL have port M_AXIS_DATA_tvalid, output, 1 bit: the beat is valid.
REQ-012 SHALL have port M_AXIS_DATA_tlast, output, 1 bit: final beat of the stream.
REQ-013 SHALL have port M_AXIS_DATA_tready, input, 1 bit: downstream accepts the beat.
REQ-014 SHALL have port o_VecCnt, output, 16 bits: vectors accepted in the current stream.

Function
REQ-015 SHALL hold a zero-initialized shift buffer of VECTOR_WIDTH+BUS_WIDTH bits and a fill level lvl (valid bits, counted from bit 0).
REQ-016 SHALL implement two states, RUN and FLUSH, and SHALL leave reset in RUN.
REQ-017 SHALL drive o_Ready = (state==RUN) && (lvl < BUS_WIDTH), combinationally from registers only.
REQ-018 On acceptance, SHALL OR i_Vector into the buffer at bit offset lvl and add VECTOR_WIDTH to lvl. Vectors SHALL be packed back-to-back with no padding between them.
REQ-019 On acceptance with i_Last=1, SHALL enter FLUSH on the next cycle.
REQ-020 SHALL drive M_AXIS_DATA_tvalid = (lvl >= BUS_WIDTH) || (state==FLUSH && lvl > 0).
REQ-021 SHALL drive M_AXIS_DATA_tdata = buffer[BUS_WIDTH-1:0]. Bits at or above lvl SHALL be zero.
REQ-022 On a beat transfer (tvalid && tready), SHALL shift the buffer right by BUS_WIDTH with zero fill, and SHALL set lvl to max(lvl-BUS_WIDTH, 0).
REQ-023 SHALL drive M_AXIS_DATA_tlast = (state==FLUSH) && (lvl <= BUS_WIDTH) && (lvl > 0).
REQ-024 After the tlast beat transfers, SHALL return to RUN with lvl=0 and o_VecCnt=0.
REQ-025 SHALL never accept a vector in the same cycle as a beat transfer. This holds by construction: o_Ready implies tvalid=0 in RUN, and o_Ready=0 in FLUSH.
REQ-026 SHALL hold tdata, tvalid and tlast stable while tvalid=1 and tready=0.
REQ-027 SHALL incur one output bubble cycle per accepted vector in RUN (lvl < BUS_WIDTH with no load); this is acceptable throughput.
REQ-028 SHALL increment o_VecCnt on each acceptance, saturating at 16'hFFFF.
REQ-029 Latency: the first beat of a vector SHALL be valid on the cycle after its acceptance.

Reset
REQ-030 ap_rst=1 SHALL asynchronously clear the buffer, lvl, state (to RUN), o_VecCnt, tvalid and tlast. With lvl=0, o_Ready is 1 after reset.
REQ-031 Reset mid-stream SHALL discard all buffered bits, and SHALL NOT emit tlast or any partial beat after reset release.

Verification
REQ-032 Single vector with i_Last=1, tready=1 -> exactly 8 beats; beat 7 has tlast=1, bits 23:0 equal to vector bits 919:896, bits 127:24 zero.
REQ-033 Three vectors, the third with i_Last=1, tready=1 -> 22 beats total; beat 21 has 72 valid bits and tlast=1; o_VecCnt reads 3 before tlast and 0 after.
REQ-034 tready toggled randomly (50%) on a 3-vector stream -> the beat sequence is identical to REQ-033, and tdata/tlast never change while tvalid=1 and tready=0.
REQ-035 i_Valid held high continuously with i_Last=0 -> o_Ready pulses once per vector; vector 2 starts at bit 920 of the stream (beat 7, bit 24); no bits are lost or duplicated.
REQ-036 ap_rst asserted during beat 4 of vector 1, then released -> tvalid=0, o_Ready=1, o_VecCnt=0; a new single-vector stream then reproduces REQ-032 exactly.
